// File: rtl/pio_pulse_sequencer_pkg.sv
// pio_pulse_sequencer_pkg
// Shared definitions for the pulse sequencer slave:
//   - Avalon register addresses (CONTROL, ON_CYCLES, OFF_CYCLES, REPEAT)
//   - bit positions inside the CONTROL register
//   - the sequencer FSM state type
package pio_pulse_sequencer_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_ON   = 2'd1;
  localparam logic [1:0] ADDR_OFF  = 2'd2;
  localparam logic [1:0] ADDR_REP  = 2'd3;

  // CONTROL write: start/stop/idle_level/irq_en/done_clear
  // CONTROL read : busy (shares bit 0 with start), idle_level, irq_en, done
  localparam int CTRL_START    = 0;
  localparam int CTRL_BUSY     = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_IDLE_LVL = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_DONE     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pio_pulse_sequencer_regs.sv
// pio_seq_regs
// Avalon-MM register file and zero-wait-state read mux for the pulse
// sequencer.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   address/chipselect/write_n   Avalon slave control
//   writedata/readdata           Avalon data (readdata is combinational)
//   busy                         FSM activity flag, reported in CONTROL
//   done_set                     one-cycle pulse from the FSM at sequence end
//   on_cycles/off_cycles         programmed phase lengths
//   rep_count                    programmed repeat count (0 = infinite)
//   idle_level/irq_en/done       CONTROL state bits
//   idle_level_next              value idle_level takes at the next edge
//   start_req/stop_req           CONTROL write command pulses
module pio_seq_regs
  import pio_pulse_sequencer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REP_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             busy,
  input  logic             done_set,
  output logic [CNT_W-1:0] on_cycles,
  output logic [CNT_W-1:0] off_cycles,
  output logic [REP_W-1:0] rep_count,
  output logic             idle_level,
  output logic             idle_level_next,
  output logic             irq_en,
  output logic             done,
  output logic             start_req,
  output logic             stop_req
);

  logic wr_en;
  logic ctrl_wr;
  logic unused_wdata;

  assign wr_en   = chipselect & ~write_n;
  assign ctrl_wr = wr_en && (address == ADDR_CTRL);

  assign start_req = ctrl_wr & writedata[CTRL_START];
  assign stop_req  = ctrl_wr & writedata[CTRL_STOP];

  // The FSM registers out_port from this so an idle_level write shows on
  // the line at the same edge the register itself changes.
  assign idle_level_next = ctrl_wr ? writedata[CTRL_IDLE_LVL] : idle_level;

  // Upper writedata bits are dropped when the registers are narrower than 32.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      on_cycles  <= '0;
      off_cycles <= '0;
      rep_count  <= '0;
      idle_level <= 1'b0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        idle_level <= writedata[CTRL_IDLE_LVL];
        irq_en     <= writedata[CTRL_IRQ_EN];
      end
      if (wr_en && (address == ADDR_ON))  on_cycles  <= writedata[CNT_W-1:0];
      if (wr_en && (address == ADDR_OFF)) off_cycles <= writedata[CNT_W-1:0];
      if (wr_en && (address == ADDR_REP)) rep_count  <= writedata[REP_W-1:0];
      // A completion in the same cycle as a clear must not be lost.
      if (done_set)
        done <= 1'b1;
      else if (ctrl_wr && writedata[CTRL_DONE])
        done <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_BUSY]     = busy;
        readdata[CTRL_IDLE_LVL] = idle_level;
        readdata[CTRL_IRQ_EN]   = irq_en;
        readdata[CTRL_DONE]     = done;
      end
      ADDR_ON:  readdata[CNT_W-1:0] = on_cycles;
      ADDR_OFF: readdata[CNT_W-1:0] = off_cycles;
      ADDR_REP: readdata[REP_W-1:0] = rep_count;
      default:  readdata = '0;
    endcase
  end

endmodule

// File: rtl/pio_pulse_sequencer.sv
// pio_pulse_sequencer
// Avalon-MM slave generating a programmable pulse train on one output line:
// max(ON,1) cycles high, max(OFF,1) cycles low, repeated REPEAT times
// (REPEAT=0 runs until stopped). Completion sets a sticky done bit.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   address/chipselect/write_n   Avalon slave control
//   writedata/readdata           Avalon data, zero-wait-state reads
//   out_port                     registered sequenced output
//   irq                          level interrupt, done & irq_en
module pio_pulse_sequencer
  import pio_pulse_sequencer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REP_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  seq_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [REP_W-1:0] rep, rep_d;
  logic             inf, inf_d;
  logic             out_d;
  logic             done_set;
  logic             busy;

  logic [CNT_W-1:0] on_cycles;
  logic [CNT_W-1:0] off_cycles;
  logic [REP_W-1:0] rep_count;
  logic             idle_level;
  logic             idle_level_next;
  logic             irq_en;
  logic             done;
  logic             start_req;
  logic             stop_req;

  logic [CNT_W-1:0] on_load;
  logic [CNT_W-1:0] off_load;

  pio_seq_regs #(
    .CNT_W(CNT_W),
    .REP_W(REP_W)
  ) u_regs (
    .clk             (clk),
    .reset_n         (reset_n),
    .address         (address),
    .chipselect      (chipselect),
    .write_n         (write_n),
    .writedata       (writedata),
    .readdata        (readdata),
    .busy            (busy),
    .done_set        (done_set),
    .on_cycles       (on_cycles),
    .off_cycles      (off_cycles),
    .rep_count       (rep_count),
    .idle_level      (idle_level),
    .idle_level_next (idle_level_next),
    .irq_en          (irq_en),
    .done            (done),
    .start_req       (start_req),
    .stop_req        (stop_req)
  );

  assign busy = (state != ST_IDLE);
  assign irq  = done & irq_en;

  // A zero phase length would make the down-counter wrap; force it to 1.
  assign on_load  = (on_cycles  == '0) ? CNT_W'(1) : on_cycles;
  assign off_load = (off_cycles == '0) ? CNT_W'(1) : off_cycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rep      <= '0;
      inf      <= 1'b0;
      out_port <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rep      <= rep_d;
      inf      <= inf_d;
      out_port <= out_d;
    end
  end

  // cnt holds the cycles left in the current phase including this one, so a
  // phase ends on the cycle cnt==1. inf latches REPEAT==0 at start so later
  // REPEAT writes cannot turn a running infinite sequence into a finite one.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    rep_d    = rep;
    inf_d    = inf;
    done_set = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_req && !stop_req) begin
          state_d = ST_ON;
          cnt_d   = on_load;
          rep_d   = rep_count;
          inf_d   = (rep_count == '0);
        end
      end

      ST_ON: begin
        if (stop_req) begin
          state_d = ST_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_d = ST_OFF;
          cnt_d   = off_load;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      ST_OFF: begin
        if (stop_req) begin
          state_d = ST_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          if (inf) begin
            state_d = ST_ON;
            cnt_d   = on_load;
          end else if (rep == REP_W'(1)) begin
            state_d  = ST_IDLE;
            done_set = 1'b1;
          end else begin
            state_d = ST_ON;
            cnt_d   = on_load;
            rep_d   = rep - REP_W'(1);
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // out_port is registered from the next state so the line follows the
  // phase with no extra cycle of lag.
  always_comb begin
    out_d = idle_level_next;
    case (state_d)
      ST_ON:   out_d = 1'b1;
      ST_OFF:  out_d = 1'b0;
      default: out_d = idle_level_next;
    endcase
  end

endmodule

// File: tb/tb_pio_pulse_sequencer.sv
// tb_pio_pulse_sequencer
// Self-checking bench for pio_pulse_sequencer. A waveform-queue model
// predicts out_port and irq each cycle; directed scenarios add literal
// pattern and register readback checks.
module tb_pio_pulse_sequencer;

  localparam int CNT_W = 16;
  localparam int REP_W = 16;

  localparam logic [31:0] C_START = 32'h01;
  localparam logic [31:0] C_STOP  = 32'h02;
  localparam logic [31:0] C_IDLE  = 32'h04;
  localparam logic [31:0] C_IRQEN = 32'h08;
  localparam logic [31:0] C_DCLR  = 32'h10;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;
  bit compareEn   = 0;

  logic capOut [128];
  logic capIrq [128];

  pio_pulse_sequencer #(
    .CNT_W(CNT_W),
    .REP_W(REP_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: the expected line is a queue of future output bits. Each edge
  // pops one; when a phase is exhausted the next phase is appended using
  // the register values held just before that edge.
  bit          mRun      = 0;
  bit          mInf      = 0;
  bit          mLastOn   = 0;
  int unsigned mRepsLeft = 0;
  bit          mWave[$];
  int unsigned mOn       = 0;
  int unsigned mOff      = 0;
  int unsigned mRep      = 0;
  bit          mIdle     = 0;
  bit          mIrqEn    = 0;
  bit          mDone     = 0;

  task automatic pushPhase(input bit isOn, input int unsigned len);
    int unsigned n;
    n = (len == 0) ? 1 : len;
    for (int unsigned k = 0; k < n; k++) mWave.push_back(isOn);
    mLastOn = isOn;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mRun = 0; mInf = 0; mLastOn = 0; mRepsLeft = 0; mWave.delete();
      mOn = 0; mOff = 0; mRep = 0; mIdle = 0; mIrqEn = 0; mDone = 0;
    end else begin
      bit wr, ctrlWr, st, sp, setDone;
      wr      = chipselect && !write_n;
      ctrlWr  = wr && (address == 2'd0);
      st      = ctrlWr && writedata[0];
      sp      = ctrlWr && writedata[1];
      setDone = 0;
      if (mRun) begin
        if (sp) begin
          mRun = 0;
          mWave.delete();
        end else begin
          void'(mWave.pop_front());
          if (mWave.size() == 0) begin
            if (mLastOn) pushPhase(0, mOff);
            else if (mInf || mRepsLeft > 1) begin
              if (!mInf) mRepsLeft--;
              pushPhase(1, mOn);
            end else begin
              mRun = 0;
              setDone = 1;
            end
          end
        end
      end else if (st && !sp) begin
        mRun      = 1;
        mInf      = (mRep == 0);
        mRepsLeft = mRep;
        pushPhase(1, mOn);
      end
      if (setDone) mDone = 1;
      else if (ctrlWr && writedata[4]) mDone = 0;
      if (ctrlWr) begin
        mIdle  = writedata[2];
        mIrqEn = writedata[3];
      end
      if (wr && address == 2'd1) mOn  = writedata & 32'h0000_FFFF;
      if (wr && address == 2'd2) mOff = writedata & 32'h0000_FFFF;
      if (wr && address == 2'd3) mRep = writedata & 32'h0000_FFFF;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (compareEn) begin
      bit eo;
      eo = (mRun && mWave.size() > 0) ? mWave[0] : mIdle;
      checkOutput("model_out", {31'b0, out_port}, {31'b0, eo});
      checkOutput("model_irq", {31'b0, irq}, {31'b0, mDone & mIrqEn});
    end
  end

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic captureOut(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      capOut[i] = out_port;
      capIrq[i] = irq;
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit finitePat [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
    bit zeroPat   [7]  = '{1, 0, 1, 0, 1, 0, 0};
    bit confPat   [14] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    compareEn = 1;

    $display("[TB] reset mid-run");
    applyStimulus(2'd1, 32'd4);
    applyStimulus(2'd2, 32'd4);
    applyStimulus(2'd0, C_START | C_IDLE);
    waitCycles(2);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_out", {31'b0, out_port}, 32'd0);
    waitCycles(2);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      readReg(a[1:0], rd);
      checkOutput($sformatf("rst_read[%0d]", a), rd, 32'd0);
    end
    checkOutput("rst_out", {31'b0, out_port}, 32'd0);
    checkOutput("rst_irq", {31'b0, irq}, 32'd0);

    $display("[TB] finite run ON=3 OFF=2 REPEAT=2");
    applyStimulus(2'd1, 32'd3);
    applyStimulus(2'd2, 32'd2);
    applyStimulus(2'd3, 32'd2);
    applyStimulus(2'd0, C_START | C_IRQEN);
    captureOut(11);
    for (int i = 0; i < 11; i++)
      checkOutput($sformatf("finite_pat[%0d]", i), {31'b0, capOut[i]},
                  {31'b0, finitePat[i]});
    checkOutput("finite_irq_before", {31'b0, capIrq[9]}, 32'd0);
    checkOutput("finite_irq_at_end", {31'b0, capIrq[10]}, 32'd1);
    readReg(2'd0, rd);
    checkOutput("finite_ctrl_done", rd, 32'h18);
    applyStimulus(2'd0, C_DCLR | C_IRQEN);
    checkOutput("done_clear_irq", {31'b0, irq}, 32'd0);
    readReg(2'd0, rd);
    checkOutput("done_clear_ctrl", rd, 32'h08);

    $display("[TB] zero-length phases REPEAT=3");
    applyStimulus(2'd1, 32'd0);
    applyStimulus(2'd2, 32'd0);
    applyStimulus(2'd3, 32'd3);
    applyStimulus(2'd0, C_START | C_IRQEN);
    captureOut(7);
    for (int i = 0; i < 7; i++)
      checkOutput($sformatf("zero_pat[%0d]", i), {31'b0, capOut[i]},
                  {31'b0, zeroPat[i]});
    readReg(2'd0, rd);
    checkOutput("zero_ctrl_done", rd, 32'h18);
    applyStimulus(2'd0, C_DCLR);
    readReg(2'd0, rd);
    checkOutput("zero_ctrl_clear", rd, 32'h00);

    $display("[TB] infinite run then stop");
    applyStimulus(2'd1, 32'd1);
    applyStimulus(2'd2, 32'd1);
    applyStimulus(2'd3, 32'd0);
    applyStimulus(2'd0, C_START | C_IDLE);
    captureOut(100);
    for (int i = 0; i < 100; i++)
      checkOutput($sformatf("inf_pat[%0d]", i), {31'b0, capOut[i]},
                  {31'b0, ((i % 2) == 0)});
    applyStimulus(2'd0, C_STOP | C_IDLE);
    checkOutput("stop_out", {31'b0, out_port}, 32'd1);
    readReg(2'd0, rd);
    checkOutput("stop_ctrl", rd, 32'h04);

    $display("[TB] start+stop together, start while busy, ON change mid-run");
    applyStimulus(2'd0, C_START | C_STOP | C_IDLE);
    readReg(2'd0, rd);
    checkOutput("startstop_ctrl", rd, 32'h04);
    checkOutput("startstop_out", {31'b0, out_port}, 32'd1);
    applyStimulus(2'd1, 32'd2);
    applyStimulus(2'd2, 32'd3);
    applyStimulus(2'd3, 32'd2);
    applyStimulus(2'd0, C_START | C_IDLE);
    fork
      captureOut(14);
      begin
        applyStimulus(2'd1, 32'd5);
        applyStimulus(2'd0, C_START | C_IDLE);
      end
    join
    for (int i = 0; i < 14; i++)
      checkOutput($sformatf("conf_pat[%0d]", i), {31'b0, capOut[i]},
                  {31'b0, confPat[i]});
    readReg(2'd0, rd);
    checkOutput("conf_ctrl_done", rd, 32'h14);

    $display("[TB] width and readback");
    applyStimulus(2'd1, 32'hFFFF_FFFF);
    readReg(2'd1, rd);
    checkOutput("width_on", rd, 32'h0000_FFFF);
    applyStimulus(2'd2, 32'h0001_2345);
    readReg(2'd2, rd);
    checkOutput("width_off", rd, 32'h0000_2345);
    applyStimulus(2'd3, 32'hFFFF_FFFF);
    readReg(2'd3, rd);
    checkOutput("width_rep", rd, 32'h0000_FFFF);
    applyStimulus(2'd0, 32'hFFFF_FFE0);
    readReg(2'd0, rd);
    checkOutput("ctrl_reserved", rd, 32'h10);
    waitCycles(3);

    compareEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
